// File: rtl/mult_div_hilo_pkg.sv
// Shared types and defaults for the HI/LO multiply/divide unit.
package mult_div_hilo_pkg;

    localparam int unsigned WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MULT   = 2'd1,
        DIV    = 2'd2,
        FINISH = 2'd3
    } state_e;

endpackage

// File: rtl/div_restoring_step.sv
// One restoring-division iteration: shift {remainder, quotient} left and trial-subtract the divisor.
module div_restoring_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] divisor_ext;
    logic           ge;

    always_comb begin
        shifted     = {rem_i, quo_i[WIDTH-1]};
        divisor_ext = {1'b0, divisor_i};
        ge          = (shifted >= divisor_ext);
        // When the trial fails, shifted < divisor, so it fits in WIDTH bits.
        rem_o       = ge ? WIDTH'(shifted - divisor_ext) : shifted[WIDTH-1:0];
        quo_o       = {quo_i[WIDTH-2:0], ge};
    end

endmodule

// File: rtl/mult_div_hilo.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring) unit owning the HI and LO registers.
module mult_div_hilo
    import mult_div_hilo_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned ITER  = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int unsigned CW = (ITER > 1) ? $clog2(ITER) : 1;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] ql_q, ql_d;
    logic [WIDTH-1:0] opd_q, opd_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             qm1_q, qm1_d;
    logic             is_div_q, is_div_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;
    logic             dz_pend_q, dz_pend_d;

    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] rem_nx, quo_nx;

    assign a_mag = in_a[WIDTH-1] ? WIDTH'(-in_a) : in_a;
    assign b_mag = in_b[WIDTH-1] ? WIDTH'(-in_b) : in_b;

    // Booth add/subtract; accumulator is one bit wider so -(-2^(W-1)) cannot overflow.
    always_comb begin
        m_ext = {opd_q[WIDTH-1], opd_q};
        case ({ql_q[0], qm1_q})
            2'b01:   booth_sum = acc_q + m_ext;
            2'b10:   booth_sum = acc_q - m_ext;
            default: booth_sum = acc_q;
        endcase
    end

    div_restoring_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .rem_i    (acc_q[WIDTH-1:0]),
        .quo_i    (ql_q),
        .divisor_i(opd_q),
        .rem_o    (rem_nx),
        .quo_o    (quo_nx)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        ql_d      = ql_q;
        qm1_d     = qm1_q;
        opd_d     = opd_q;
        is_div_d  = is_div_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = (state_q == MULT) || (state_q == DIV);
        done_d    = 1'b0;
        dz_d      = 1'b0;
        dz_pend_d = 1'b0;

        case (state_q)
            IDLE: begin
                // Starts are dropped while a completion pulse is pending or visible.
                if (dz_pend_q) begin
                    done_d = 1'b1;
                    dz_d   = 1'b1;
                end else if (!done_q) begin
                    if (start_mult) begin
                        acc_d    = '0;
                        ql_d     = in_b;
                        qm1_d    = 1'b0;
                        opd_d    = in_a;
                        is_div_d = 1'b0;
                        cnt_d    = CW'(ITER - 1);
                        state_d  = MULT;
                    end else if (start_div) begin
                        if (in_b == '0) begin
                            dz_pend_d = 1'b1;
                        end else begin
                            acc_d     = '0;
                            ql_d      = a_mag;
                            opd_d     = b_mag;
                            neg_quo_d = in_a[WIDTH-1] ^ in_b[WIDTH-1];
                            neg_rem_d = in_a[WIDTH-1];
                            is_div_d  = 1'b1;
                            cnt_d     = CW'(ITER - 1);
                            state_d   = DIV;
                        end
                    end
                end
            end
            MULT: begin
                acc_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                ql_d  = {booth_sum[0], ql_q[WIDTH-1:1]};
                qm1_d = ql_q[0];
                if (cnt_q == '0) state_d = FINISH;
                else             cnt_d   = cnt_q - 1'b1;
            end
            DIV: begin
                acc_d = {1'b0, rem_nx};
                ql_d  = quo_nx;
                if (cnt_q == '0) state_d = FINISH;
                else             cnt_d   = cnt_q - 1'b1;
            end
            FINISH: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (is_div_q) begin
                    hi_d = neg_rem_q ? WIDTH'(-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
                    lo_d = neg_quo_q ? WIDTH'(-ql_q) : ql_q;
                end else begin
                    hi_d = acc_q[WIDTH-1:0];
                    lo_d = ql_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            ql_q      <= '0;
            qm1_q     <= 1'b0;
            opd_q     <= '0;
            is_div_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
            dz_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            ql_q      <= ql_d;
            qm1_q     <= qm1_d;
            opd_q     <= opd_d;
            is_div_q  <= is_div_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
            dz_pend_q <= dz_pend_d;
        end
    end

    assign hi_out   = hi_q;
    assign lo_out   = lo_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_mult_div_hilo.sv
// Directed bench for mult_div_hilo with a cycle-timeline reference model and literal spot checks.
module tb_mult_div_hilo;

    localparam int ITER = 32;

    logic        clk        = 1'b0;
    logic        reset      = 1'b0;
    logic        start_mult = 1'b0;
    logic        start_div  = 1'b0;
    logic [31:0] in_a       = '0;
    logic [31:0] in_b       = '0;
    logic [31:0] hi_out, lo_out;
    logic        busy, done, div_zero;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    mult_div_hilo dut (
        .clk       (clk),
        .reset     (reset),
        .start_mult(start_mult),
        .start_div (start_div),
        .in_a      (in_a),
        .in_b      (in_b),
        .hi_out    (hi_out),
        .lo_out    (lo_out),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: an accepted start produces its arithmetic result ITER+1 edges later.
    logic [31:0] m_hi = '0, m_lo = '0, r_hi = '0, r_lo = '0;
    bit          m_busy = 0, m_done = 0, m_dz = 0, m_active = 0, m_dzp = 0, done_vis = 0;
    int          m_j = 0;
    longint      la, lb, res_q, res_r, prod;

    always @(posedge clk) begin
        if (!reset) begin
            m_hi = '0; m_lo = '0; m_busy = 0; m_done = 0; m_dz = 0;
            m_active = 0; m_dzp = 0; m_j = 0;
        end else begin
            done_vis = m_done;
            m_done   = 0;
            m_dz     = 0;
            if (m_dzp) begin
                m_done = 1; m_dz = 1; m_dzp = 0;
            end else if (m_active) begin
                m_j++;
                if (m_j == ITER + 1) begin
                    m_hi = r_hi; m_lo = r_lo; m_done = 1; m_active = 0;
                end
            end else if (!done_vis) begin
                la = longint'($signed(in_a));
                lb = longint'($signed(in_b));
                if (start_mult) begin
                    prod = la * lb;
                    r_hi = prod[63:32];
                    r_lo = prod[31:0];
                    m_active = 1; m_j = 0;
                end else if (start_div) begin
                    if (lb == 0) begin
                        m_dzp = 1;
                    end else begin
                        res_q = la / lb;
                        res_r = la % lb;
                        r_lo = res_q[31:0];
                        r_hi = res_r[31:0];
                        m_active = 1; m_j = 0;
                    end
                end
            end
            m_busy = m_active && (m_j >= 1) && (m_j <= ITER);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_hi", hi_out, m_hi);
            check("cyc_lo", lo_out, m_lo);
            check("cyc_busy", {31'b0, busy}, {31'b0, m_busy});
            check("cyc_done", {31'b0, done}, {31'b0, m_done});
            check("cyc_div_zero", {31'b0, div_zero}, {31'b0, m_dz});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        start_mult = m;
        start_div  = d;
        in_a       = a;
        in_b       = b;
        tick();
        start_mult = 1'b0;
        start_div  = 1'b0;
        in_a       = 32'hDEAD_BEEF;
        in_b       = 32'h1234_5678;
    endtask

    task automatic wait_done(output int n, output int bn);
        n  = 0;
        bn = 0;
        while (n < 60) begin
            tick();
            n++;
            if (busy === 1'b1) bn++;
            if (done === 1'b1) break;
        end
    endtask

    task automatic run_op(input string name, input logic m, input logic d,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n, bn;
        start_op(m, d, a, b);
        wait_done(n, bn);
        check({name, "_latency"}, 32'(n), 32'd33);
        check({name, "_busy_cycles"}, 32'(bn), 32'd32);
        check({name, "_hi"}, hi_out, exp_hi);
        check({name, "_lo"}, lo_out, exp_lo);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, bn, dcnt;
        reset = 1'b0;
        repeat (3) tick();
        cmp_en = 1'b1;
        check("rst_hi", hi_out, 32'h0);
        check("rst_lo", lo_out, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_done", {31'b0, done}, 32'h0);
        check("rst_div_zero", {31'b0, div_zero}, 32'h0);
        reset = 1'b1;
        tick();

        run_op("mul_mixed",   1, 0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("mul_minneg",  1, 0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_op("div_neg",     0, 1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_pos",     0, 1, 32'd100,      32'd7,         32'd2,         32'd14);
        run_op("div_negdvs",  0, 1, 32'd7,        32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD);
        run_op("div_ovf",     0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000);
        run_op("preload",     0, 1, 32'h451,      32'h20,        32'h11,        32'h22);

        // Divide by zero: pulse one cycle later, HI/LO untouched, never busy.
        start_op(0, 1, 32'd5, 32'd0);
        check("dz_busy_start", {31'b0, busy}, 32'h0);
        tick();
        check("dz_done", {31'b0, done}, 32'h1);
        check("dz_flag", {31'b0, div_zero}, 32'h1);
        check("dz_busy", {31'b0, busy}, 32'h0);
        check("dz_hi", hi_out, 32'h11);
        check("dz_lo", lo_out, 32'h22);
        tick();
        check("dz_done_clear", {31'b0, done}, 32'h0);
        check("dz_flag_clear", {31'b0, div_zero}, 32'h0);
        tick();

        // A divide issued while the multiply is running is ignored.
        start_op(1, 0, 32'd5, 32'd6);
        repeat (4) tick();
        start_op(0, 1, 32'd100, 32'd7);
        wait_done(n, bn);
        check("busy_ign_latency", 32'(5 + n), 32'd33);
        check("busy_ign_hi", hi_out, 32'h0);
        check("busy_ign_lo", lo_out, 32'd30);
        tick();

        run_op("simul", 1, 1, 32'd9, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFD3);

        // A start presented during the done cycle is dropped.
        start_op(1, 0, 32'd3, 32'd3);
        wait_done(n, bn);
        check("dcyc_lo", lo_out, 32'd9);
        start_op(1, 0, 32'h100, 32'h100);
        repeat (3) tick();
        check("dcyc_busy", {31'b0, busy}, 32'h0);
        check("dcyc_hi", hi_out, 32'h0);
        check("dcyc_lo_hold", lo_out, 32'd9);

        // Reset in the middle of a divide aborts it.
        start_op(0, 1, 32'd100, 32'd7);
        repeat (9) tick();
        reset = 1'b0;
        tick();
        check("mid_rst_hi", hi_out, 32'h0);
        check("mid_rst_lo", lo_out, 32'h0);
        check("mid_rst_busy", {31'b0, busy}, 32'h0);
        check("mid_rst_done", {31'b0, done}, 32'h0);
        reset = 1'b1;
        dcnt = 0;
        repeat (40) begin
            tick();
            if (done === 1'b1) dcnt++;
        end
        check("mid_rst_no_done", 32'(dcnt), 32'd0);

        run_op("post_reset", 1, 0, 32'd3, 32'd4, 32'h0, 32'd12);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_div_hilo.md
Name: mult_div_hilo

Overview:
- Multicycle signed multiply/divide unit for the CPU datapath.
- Owns the architectural HI and LO registers and is their only writer.
- HI/LO values drive the HI and LO inputs of the register-write data selector (MFHI/MFLO path).
- Started by the control unit with a one-cycle pulse; reports completion with a one-cycle done pulse.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- ITER, WIDTH, number of iteration cycles for both mult and div.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (0 = reset).
- start_mult  in  1  one-cycle pulse; begin signed A*B.
- start_div  in  1  one-cycle pulse; begin signed A/B.
- in_a  in  WIDTH  operand A (multiplicand / dividend), sampled on the start edge only.
- in_b  in  WIDTH  operand B (multiplier / divisor), sampled on the start edge only.
- hi_out  out  WIDTH  HI register.
- lo_out  out  WIDTH  LO register.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- div_zero  out  1  one-cycle pulse with done when the divisor is 0.

Behaviour:
- Reset (reset==0 at a clk edge), taking priority over everything:
  - hi_out=0, lo_out=0, busy=0, done=0, div_zero=0; state=IDLE.
  - Any in-flight operation is aborted and its partial result discarded.
- FSM states: IDLE, MULT, DIV, FINISH.
- IDLE:
  - start_mult at edge k: latch operands, state=MULT, busy=1.
  - start_div with in_b!=0: state=DIV, busy=1.
  - start_div with in_b==0: stay IDLE; at edge k+1 done=1 and div_zero=1 for one cycle; HI/LO unchanged; busy stays 0.
  - start_mult and start_div both high: mult wins; div ignored.
- MULT: radix-2 Booth, one step per edge, counter from ITER-1 to 0. After ITER steps go to FINISH.
- DIV: restoring division on operand magnitudes, one quotient bit per edge, ITER steps, then FINISH.
- FINISH (one cycle):
  - HI/LO written.
  - done=1 for exactly that cycle; busy=0 from that cycle on.
  - Next state IDLE.
- Latency: start at edge k → hi_out/lo_out valid and done=1 after edge k+ITER+1 (33 for WIDTH=32).
- busy is high after edges k+1 through k+ITER.
- Mult result: 64-bit two's-complement product; HI=[63:32], LO=[31:0].
- Div result:
  - LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - Overflow case 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (wrap, no flag).
- start_* while busy=1 is ignored; operands and result are unaffected.
- A start in the same cycle as done (FINISH state) is ignored; the controller must issue it after done.
- HI/LO hold their values between operations. They change only in FINISH or on reset.
- done and div_zero are never high at the same time as busy.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, MULT=2'd1, DIV=2'd2, FINISH=2'd3;
  - WIDTH default.
- Natural sub-module: div_restoring_step. It is purely combinational: one trial subtract/shift of {remainder, quotient}. It is instantiated once and iterated by the FSM.
- The Booth step stays inline in the top.

Test Plan:
- Mult, mixed sign: reset, then start_mult with in_a=7, in_b=0xFFFFFFFD (-3) → done exactly 33 cycles after the start edge; hi_out=0xFFFFFFFF, lo_out=0xFFFFFFEB; busy high for 32 cycles.
- Mult, most-negative operands: in_a=in_b=0x80000000 → hi_out=0x40000000, lo_out=0x00000000.
- Signed div with remainder: in_a=0xFFFFFFF9 (-7), in_b=2 → lo_out=0xFFFFFFFD (-3), hi_out=0xFFFFFFFF (-1); then in_a=100, in_b=7 → lo_out=14, hi_out=2.
- Divide by zero: preload HI=0x11, LO=0x22 via a prior op, then start_div with in_b=0 → done=div_zero=1 one cycle later, busy never high, HI/LO still 0x11/0x22.
- Start while busy, and simultaneous starts:
  - start_mult, then start_div pulsed 5 cycles later with different operands → only the mult result appears, at cycle 33.
  - Simultaneous start_mult+start_div → mult result.
- Reset mid-operation: start_div 100/7, drive reset=0 at cycle 10 → next edge hi_out=lo_out=0, busy=0, no done pulse. A new mult 3*4 afterwards gives LO=12, HI=0.
